// File: rtl/vga_stream_gen_pkg.sv
// Shared definitions for the 26-bit VGA pixel stream: field positions, the
// packed word layout and the default 640x480@60 timing.
package vga_stream_gen_pkg;

  localparam int COORD_W  = 10;
  localparam int STREAM_W = 26;

  // Field positions inside the stream word, shared with every drawing stage.
  localparam int RGB_HI  = 25;
  localparam int RGB_LO  = 23;
  localparam int XC_HI   = 22;
  localparam int XC_LO   = 13;
  localparam int YC_HI   = 12;
  localparam int YC_LO   = 3;
  localparam int ACT_BIT = 2;
  localparam int HS_BIT  = 1;
  localparam int VS_BIT  = 0;
  localparam int VGA_HI  = 22;
  localparam int VGA_LO  = 0;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic [2:0] rgb;
    coord_t     xc;
    coord_t     yc;
    logic       active;
    logic       hsync;
    logic       vsync;
  } stream_word_t;

endpackage

// File: rtl/vga_stream_gen_wrap_counter.sv
// Modulo counter 0..MAX that advances when en is high; wrap flags the
// enabled cycle on which it returns to zero.
module wrap_counter
  import vga_stream_gen_pkg::*;
#(
  parameter int MAX = 799
) (
  input  logic               px_clk,
  input  logic               rst_n,
  input  logic               en,
  output logic [COORD_W-1:0] cnt,
  output logic               wrap
);

  localparam logic [COORD_W-1:0] MAX_C = COORD_W'(MAX);

  assign wrap = en && (cnt == MAX_C);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would let h/v ordering leak into results.
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + COORD_W'(1);
    end
  end

endmodule

// File: rtl/vga_stream_gen.sv
// Head of the pixel stream: horizontal/vertical timing counters decoded into
// one registered stream word per px_clk, plus a frame-start pulse.
module vga_stream_gen
  import vga_stream_gen_pkg::*;
#(
  parameter int         H_ACTIVE = DEF_H_ACTIVE,
  parameter int         H_FP     = DEF_H_FP,
  parameter int         H_SYNC   = DEF_H_SYNC,
  parameter int         H_BP     = DEF_H_BP,
  parameter int         V_ACTIVE = DEF_V_ACTIVE,
  parameter int         V_FP     = DEF_V_FP,
  parameter int         V_SYNC   = DEF_V_SYNC,
  parameter int         V_BP     = DEF_V_BP,
  parameter logic       SYNC_POL = 1'b0,
  parameter logic [2:0] BG_COLOR = 3'b000
) (
  input  logic                px_clk,
  input  logic                rst_n,
  output logic [STREAM_W-1:0] strRGB_o,
  output logic                frame_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
    $error("vga_stream_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  localparam coord_t H_ACT_END = COORD_W'(H_ACTIVE);
  localparam coord_t HS_START  = COORD_W'(H_ACTIVE + H_FP);
  localparam coord_t HS_END    = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t V_ACT_END = COORD_W'(V_ACTIVE);
  localparam coord_t VS_START  = COORD_W'(V_ACTIVE + V_FP);
  localparam coord_t VS_END    = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam stream_word_t RESET_WORD = '{
    rgb: 3'b000, xc: '0, yc: '0, active: 1'b0, hsync: ~SYNC_POL, vsync: ~SYNC_POL
  };

  coord_t       h_cnt;
  coord_t       v_cnt;
  logic         h_wrap;
  logic         v_wrap;
  stream_word_t nxt_word;
  logic         nxt_frame;
  stream_word_t str_q;
  logic         frame_q;

  wrap_counter #(.MAX(H_TOTAL - 1)) u_h_cnt (
    .px_clk (px_clk),
    .rst_n  (rst_n),
    .en     (1'b1),
    .cnt    (h_cnt),
    .wrap   (h_wrap)
  );

  wrap_counter #(.MAX(V_TOTAL - 1)) u_v_cnt (
    .px_clk (px_clk),
    .rst_n  (rst_n),
    .en     (h_wrap),
    .cnt    (v_cnt),
    .wrap   (v_wrap)
  );

  // NOTE: every field gets a default before the decode so no path through
  // this block can leave a signal unassigned and infer a latch.
  always_comb begin
    nxt_word        = RESET_WORD;
    nxt_word.xc     = h_cnt;
    nxt_word.yc     = v_cnt;
    nxt_word.active = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    nxt_word.hsync  = (h_cnt >= HS_START && h_cnt < HS_END) ? SYNC_POL : ~SYNC_POL;
    nxt_word.vsync  = (v_cnt >= VS_START && v_cnt < VS_END) ? SYNC_POL : ~SYNC_POL;
    nxt_word.rgb    = nxt_word.active ? BG_COLOR : 3'b000;
    nxt_frame       = (h_cnt == '0) && (v_cnt == '0);
  end

  // NOTE: the output registers are reset so downstream stages see idle sync
  // levels, not X, the moment rst_n drops.
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      str_q   <= RESET_WORD;
      frame_q <= 1'b0;
    end else begin
      str_q   <= nxt_word;
      frame_q <= nxt_frame;
    end
  end

  assign strRGB_o = str_q;
  assign frame_o  = frame_q;

  // End of the last line must bring both counters back to the origin.
  a_frame_wrap : assert property (@(posedge px_clk) disable iff (!rst_n)
    v_wrap |=> (h_cnt == '0 && v_cnt == '0));

endmodule

// File: tb/tb_vga_stream_gen.sv
// Scoreboard bench for vga_stream_gen: one instance at default 640x480 timing
// and one small-raster instance with active-high sync for frame-level checks.
module tb_vga_stream_gen;

  localparam logic [2:0] FULL_BG  = 3'b101;
  localparam logic [2:0] SMALL_BG = 3'b011;
  localparam int S_HA = 40, S_HFP = 4, S_HS = 8, S_HBP = 6;
  localparam int S_VA = 20, S_VFP = 3, S_VS = 2, S_VBP = 5;
  localparam int S_HT = S_HA + S_HFP + S_HS + S_HBP;  // 58
  localparam int S_VT = S_VA + S_VFP + S_VS + S_VBP;  // 30
  localparam int S_FRAME = S_HT * S_VT;               // 1740

  logic        px_clk = 1'b0;
  logic        rst_n  = 1'b0;
  logic [25:0] full_str;
  logic        full_frame;
  logic [25:0] small_str;
  logic        small_frame;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [25:0] fw;
    logic        ff;
    logic [25:0] sw;
    logic        sf;
  } exp_t;

  exp_t sb[$];
  int fh = 0, fv = 0, sh = 0, sv = 0;

  always #5 px_clk = ~px_clk;

  vga_stream_gen #(.BG_COLOR(FULL_BG)) dut_full (
    .px_clk   (px_clk),
    .rst_n    (rst_n),
    .strRGB_o (full_str),
    .frame_o  (full_frame)
  );

  vga_stream_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
    .SYNC_POL(1'b1), .BG_COLOR(SMALL_BG)
  ) dut_small (
    .px_clk   (px_clk),
    .rst_n    (rst_n),
    .strRGB_o (small_str),
    .frame_o  (small_frame)
  );

  function automatic logic [25:0] exp_word(int h, int v, int ha, int hfp, int hsw,
                                           int va, int vfp, int vsw, logic pol,
                                           logic [2:0] bg);
    logic act, hs, vs;
    act = (h < ha) && (v < va);
    hs  = (h >= ha + hfp && h < ha + hfp + hsw) ? pol : ~pol;
    vs  = (v >= va + vfp && v < va + vfp + vsw) ? pol : ~pol;
    return {act ? bg : 3'b000, 10'(h), 10'(v), act, hs, vs};
  endfunction

  // Push the expected words for the pixel the DUTs load on the next edge,
  // then step the model raster and let the edge happen.
  task automatic run_cycle();
    exp_t e;
    e.fw = exp_word(fh, fv, 640, 16, 96, 480, 10, 2, 1'b0, FULL_BG);
    e.ff = (fh == 0 && fv == 0);
    e.sw = exp_word(sh, sv, S_HA, S_HFP, S_HS, S_VA, S_VFP, S_VS, 1'b1, SMALL_BG);
    e.sf = (sh == 0 && sv == 0);
    sb.push_back(e);
    fh++;
    if (fh == 800) begin fh = 0; fv = (fv == 524) ? 0 : fv + 1; end
    sh++;
    if (sh == S_HT) begin sh = 0; sv = (sv == S_VT - 1) ? 0 : sv + 1; end
    @(posedge px_clk);
    #1;
  endtask

  task automatic model_reset();
    fh = 0; fv = 0; sh = 0; sv = 0;
    sb.delete();
  endtask

  task automatic do_reset();
    @(negedge px_clk);
    rst_n = 1'b0;
    @(negedge px_clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    repeat (5) begin
      @(posedge px_clk);
      #1;
      checks++;
      if (full_str !== 26'h0000003 || full_frame !== 1'b0) begin
        errors++;
        $display("FAIL reset_full: got %h/%b expected 0000003/0", full_str, full_frame);
      end
      checks++;
      if (small_str !== 26'h0000000 || small_frame !== 1'b0) begin
        errors++;
        $display("FAIL reset_small: got %h/%b expected 0000000/0", small_str, small_frame);
      end
    end
    @(negedge px_clk);
    rst_n = 1'b1;
    model_reset();
    run_cycle();
    e = sb.pop_front();
    checks++;
    if (full_str !== e.fw || full_frame !== e.ff) begin
      errors++;
      $display("FAIL first_word_full: got %h/%b expected %h/%b", full_str, full_frame, e.fw, e.ff);
    end
    checks++;
    if (full_str[22:13] !== 10'd0 || full_str[12:3] !== 10'd0 || full_str[2] !== 1'b1 ||
        full_str[25:23] !== FULL_BG || full_frame !== 1'b1) begin
      errors++;
      $display("FAIL first_word_fields: got %h frame %b expected xc0 yc0 act1 rgb %b frame 1",
               full_str, full_frame, FULL_BG);
    end
    checks++;
    if (small_str !== e.sw || small_frame !== 1'b1) begin
      errors++;
      $display("FAIL first_word_small: got %h/%b expected %h/1", small_str, small_frame, e.sw);
    end
  endtask

  task automatic test_line_wrap();
    exp_t e;
    do_reset();
    for (int i = 0; i <= 800; i++) begin
      run_cycle();
      e = sb.pop_front();
      checks++;
      if (full_str !== e.fw || full_frame !== e.ff) begin
        errors++;
        $display("FAIL line_wrap word %0d: got %h/%b expected %h/%b", i, full_str, full_frame, e.fw, e.ff);
      end
      if (i == 799) begin
        checks++;
        if (full_str[22:13] !== 10'd799 || full_str[12:3] !== 10'd0) begin
          errors++;
          $display("FAIL line_end: got xc %0d yc %0d expected 799 0", full_str[22:13], full_str[12:3]);
        end
      end
      if (i == 800) begin
        checks++;
        if (full_str[22:13] !== 10'd0 || full_str[12:3] !== 10'd1) begin
          errors++;
          $display("FAIL line_start: got xc %0d yc %0d expected 0 1", full_str[22:13], full_str[12:3]);
        end
      end
    end
  endtask

  task automatic test_hsync();
    exp_t e;
    int low_cnt;
    logic exp_hs, exp_act;
    low_cnt = 0;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      run_cycle();
      e = sb.pop_front();
      exp_hs  = (i >= 656 && i <= 751) ? 1'b0 : 1'b1;
      exp_act = (i < 640);
      if (full_str[1] == 1'b0) low_cnt++;
      checks++;
      if (full_str[1] !== exp_hs || full_str[2] !== exp_act) begin
        errors++;
        $display("FAIL hsync_window xc %0d: got hs %b act %b expected hs %b act %b",
                 i, full_str[1], full_str[2], exp_hs, exp_act);
      end
      checks++;
      if (small_str !== e.sw) begin
        errors++;
        $display("FAIL hsync_small word %0d: got %h expected %h", i, small_str, e.sw);
      end
    end
    checks++;
    if (low_cnt != 96) begin
      errors++;
      $display("FAIL hsync_width: got %0d expected 96", low_cnt);
    end
  endtask

  task automatic test_frame_wrap();
    exp_t e;
    int pulses[$];
    logic exp_vs;
    do_reset();
    for (int n = 0; n <= 2 * S_FRAME; n++) begin
      run_cycle();
      e = sb.pop_front();
      if (small_frame === 1'b1) pulses.push_back(n);
      checks++;
      if (small_str !== e.sw || small_frame !== e.sf) begin
        errors++;
        $display("FAIL frame_small word %0d: got %h/%b expected %h/%b", n, small_str, small_frame, e.sw, e.sf);
      end
      checks++;
      if (full_str !== e.fw || full_frame !== e.ff) begin
        errors++;
        $display("FAIL frame_full word %0d: got %h/%b expected %h/%b", n, full_str, full_frame, e.fw, e.ff);
      end
      exp_vs = (small_str[12:3] == 10'd23 || small_str[12:3] == 10'd24);
      checks++;
      if (small_str[0] !== exp_vs) begin
        errors++;
        $display("FAIL vsync_lines yc %0d: got %b expected %b", small_str[12:3], small_str[0], exp_vs);
      end
      if (n == S_FRAME - 1) begin
        checks++;
        if (small_str[22:13] !== 10'd57 || small_str[12:3] !== 10'd29) begin
          errors++;
          $display("FAIL frame_last: got xc %0d yc %0d expected 57 29", small_str[22:13], small_str[12:3]);
        end
      end
      if (n == S_FRAME) begin
        checks++;
        if (small_str[22:13] !== 10'd0 || small_str[12:3] !== 10'd0 || small_frame !== 1'b1) begin
          errors++;
          $display("FAIL frame_origin: got xc %0d yc %0d frame %b expected 0 0 1",
                   small_str[22:13], small_str[12:3], small_frame);
        end
      end
    end
    checks++;
    if (pulses.size() != 3) begin
      errors++;
      $display("FAIL frame_pulse_count: got %0d expected 3", pulses.size());
    end else begin
      checks++;
      if (pulses[0] != 0 || pulses[1] != S_FRAME || pulses[2] != 2 * S_FRAME) begin
        errors++;
        $display("FAIL frame_period: got %0d %0d %0d expected 0 %0d %0d",
                 pulses[0], pulses[1], pulses[2], S_FRAME, 2 * S_FRAME);
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      run_cycle();
      e = sb.pop_front();
      checks++;
      if (full_str !== e.fw || small_str !== e.sw) begin
        errors++;
        $display("FAIL pre_reset word %0d: got %h %h expected %h %h", i, full_str, small_str, e.fw, e.sw);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (full_str !== 26'h0000003 || full_frame !== 1'b0 ||
        small_str !== 26'h0000000 || small_frame !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got %h/%b %h/%b expected 0000003/0 0000000/0",
               full_str, full_frame, small_str, small_frame);
    end
    @(negedge px_clk);
    rst_n = 1'b1;
    model_reset();
    run_cycle();
    e = sb.pop_front();
    checks++;
    if (full_str !== e.fw || full_frame !== 1'b1 || small_str !== e.sw || small_frame !== 1'b1) begin
      errors++;
      $display("FAIL restart_origin: got %h/%b %h/%b expected %h/1 %h/1",
               full_str, full_frame, small_str, small_frame, e.fw, e.sw);
    end
  endtask

  initial begin
    test_reset();
    test_line_wrap();
    test_hsync();
    test_frame_wrap();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_stream_gen.md
# vga_stream_gen

Source end of the 26-bit pixel stream consumed by the drawing stages (ball, paddles, score). It runs the horizontal/vertical timing counters on `px_clk` and emits one registered stream word per clock: pixel coordinates, sync/blank flags and a background colour that later stages overwrite. It also emits a one-cycle frame pulse for game logic, so positions change only between frames.

## Interface
Parameters:
- `H_ACTIVE`, default 640: visible pixels per line.
- `H_FP`, default 16: horizontal front porch.
- `H_SYNC`, default 96: hsync width.
- `H_BP`, default 48: horizontal back porch. `H_TOTAL` = sum = 800.
- `V_ACTIVE`, default 480: visible lines.
- `V_FP`, default 10: vertical front porch.
- `V_SYNC`, default 2: vsync width.
- `V_BP`, default 33: vertical back porch. `V_TOTAL` = sum = 525.
- `SYNC_POL`, default 0: sync level while asserted (0 = active-low).
- `BG_COLOR`, default 3'b000: RGB value for visible pixels.

Ports:
- `px_clk` input, 1: pixel clock.
- `rst_n` input, 1: asynchronous, active-low reset.
- `strRGB_o` output, 26: stream word. [25:23] RGB, [22:13] XC, [12:3] YC, [2] active, [1] hsync, [0] vsync.
- `frame_o` output, 1: one-cycle pulse coincident with the stream word for pixel (0,0).

## Operation
- Two counters: `h_cnt` 0..H_TOTAL-1, `v_cnt` 0..V_TOTAL-1, both 10 bits. `H_TOTAL` and `V_TOTAL` must each be ≤ 1024; elaboration fails otherwise.
- Each `px_clk` edge does two things:
  - Loads `strRGB_o` from the current counter values.
  - Advances the counters.
- Counter advance rules:
  - `h_cnt` increments each cycle.
  - At `h_cnt` = H_TOTAL-1, `h_cnt` wraps to 0 and `v_cnt` increments.
  - At (H_TOTAL-1, V_TOTAL-1), both counters wrap to 0.
- Stream word fields:
  - XC = `h_cnt`, YC = `v_cnt`. Raw values are carried in blanking too.
  - active = (`h_cnt` < H_ACTIVE) && (`v_cnt` < V_ACTIVE).
  - hsync = SYNC_POL when H_ACTIVE+H_FP ≤ `h_cnt` < H_ACTIVE+H_FP+H_SYNC (656..751 by default), else ~SYNC_POL.
  - vsync = SYNC_POL when V_ACTIVE+V_FP ≤ `v_cnt` < V_ACTIVE+V_FP+V_SYNC (490..491), else ~SYNC_POL. Vsync changes only on the word where XC = 0.
  - RGB = BG_COLOR when active, else 3'b000.
- `frame_o` = 1 exactly when the word being loaded has XC = 0 and YC = 0.
- All comparisons are unsigned, 10-bit. Constants are computed at elaboration; no runtime arithmetic beyond the increments.

## Timing
- Reset (`rst_n` low, asynchronous, any time including mid-line):
  - `h_cnt` = 0, `v_cnt` = 0.
  - `strRGB_o` = RGB 0, XC 0, YC 0, active 0, hsync = vsync = ~SYNC_POL.
  - `frame_o` = 0.
- First edge after `rst_n` rises: word for (0,0) with active = 1, RGB = BG_COLOR, and `frame_o` = 1.
- Edge n after release carries pixel (n mod H_TOTAL, (n div H_TOTAL) mod V_TOTAL).
- Frame period = H_TOTAL·V_TOTAL = 420000 cycles. `frame_o` repeats at exactly that period.
- Latency: zero-bubble. One word per clock, never stalled; there is no ready/valid handshake. Downstream stages add their own one-cycle registers and keep the stream coherent.
- A reset pulse in the middle of a line or frame abandons that frame. No partial-line completion.

## Structure
- Shared header/package holds:
  - Field index defines: RGB 25:23, XC 22:13, YC 12:3, ACT 2, HS 1, VS 0, VGA 22:0, shared with every drawing stage.
  - Default 640×480@60 timing constants and the 10-bit coordinate width.
- One sub-module: `wrap_counter` (parameter MAX, inputs `px_clk`, `rst_n`, `en`; outputs `cnt`, `wrap`). It is instantiated for `h_cnt` (en = 1) and `v_cnt` (en = horizontal wrap).
- The top contains only decode and output registers.

## Test plan
- Reset: hold `rst_n` low 5 cycles, then release → during reset `strRGB_o` = 0x0000003 (hs = vs = 1) and `frame_o` = 0. First edge after release: XC = 0, YC = 0, active = 1, `frame_o` = 1.
- Line wrap: run 800 cycles → word 799 has XC = 799, YC = 0. Word 800 has XC = 0, YC = 1.
- Hsync window: scan line 0 → hsync = 0 exactly for XC 656..751 (96 words) and active = 0 for XC 640..799.
- Frame wrap: run 420000 cycles → vsync = 0 only on lines 490–491. `frame_o` high once, and again exactly 420000 cycles later. The word after (799,524) is (0,0).
- Mid-frame reset: assert `rst_n` low at (300,200) for 1 cycle → outputs go to reset values immediately (asynchronously). The first edge after release yields (0,0) with `frame_o` = 1.
- Integration with the ball stage: set BG_COLOR = 3'b001 and ball pos (100,100) → on ball stage output, RGB = 3'b111 for XC, YC in 101..109 and 3'b001 elsewhere in the visible area.
